// File: rtl/onchip_mem_arbiter_if.sv
// rtl/onchip_mem_arbiter_if.sv - two-master / one-RAM bus bundle for the on-chip memory arbiter
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] m0_address;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic              m0_lock;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    logic [ADDR_W-1:0] m1_address;
    logic [BE_W-1:0]   m1_byteenable;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic              m1_lock;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
        input  mem_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
        output mem_readdata
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - round-robin two-master arbiter with lock for a single-port on-chip RAM
module onchip_mem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    onchip_mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_M0   = 2'd1,
        LOCK_M1   = 2'd2
    } lock_state_e;

    lock_state_e lock_q, lock_d;
    logic        last_grant_q, last_grant_d;
    logic        rd_valid_q, rd_valid_d;
    logic        rd_owner_q, rd_owner_d;

    logic        req0, req1;
    logic        gnt0, gnt1;
    logic        accept;
    logic        sel_write;
    logic        sel_lock;

    assign req0 = bus.m0_read | bus.m0_write;
    assign req1 = bus.m1_read | bus.m1_write;

    // Grant depends only on registered lock/last_grant state and the request lines,
    // so mem_readdata never reaches a waitrequest.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            unique case (lock_q)
                LOCK_M0: gnt0 = req0;
                LOCK_M1: gnt1 = req1;
                default: begin
                    if (req0 && req1) begin
                        gnt0 = last_grant_q;
                        gnt1 = ~last_grant_q;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
            endcase
        end
    end

    assign accept    = gnt0 | gnt1;
    assign sel_write = gnt1 ? bus.m1_write : bus.m0_write;
    assign sel_lock  = gnt1 ? bus.m1_lock  : bus.m0_lock;

    assign bus.m0_waitrequest = ~gnt0;
    assign bus.m1_waitrequest = ~gnt1;

    assign bus.mem_chipselect = accept;
    assign bus.mem_write      = accept & sel_write;
    assign bus.mem_address    = gnt1 ? bus.m1_address    : bus.m0_address;
    assign bus.mem_byteenable = gnt1 ? bus.m1_byteenable : bus.m0_byteenable;
    assign bus.mem_writedata  = gnt1 ? bus.m1_writedata  : bus.m0_writedata;

    // Read data is broadcast; only the valid strobe is steered to the owner.
    assign bus.m0_readdata      = bus.mem_readdata;
    assign bus.m1_readdata      = bus.mem_readdata;
    assign bus.m0_readdatavalid = rd_valid_q & ~rd_owner_q;
    assign bus.m1_readdatavalid = rd_valid_q &  rd_owner_q;

    always_comb begin
        lock_d       = lock_q;
        last_grant_d = last_grant_q;
        rd_owner_d   = rd_owner_q;
        rd_valid_d   = accept & ~sel_write;
        if (accept) begin
            last_grant_d = gnt1;
            if (!sel_write) begin
                rd_owner_d = gnt1;
            end
            // Only the owner can be accepted while locked, so an unlocked accept releases it.
            if (sel_lock) begin
                lock_d = gnt1 ? LOCK_M1 : LOCK_M0;
            end else begin
                lock_d = LOCK_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q       <= LOCK_NONE;
            last_grant_q <= 1'b1;
            rd_valid_q   <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            last_grant_q <= last_grant_d;
            rd_valid_q   <= rd_valid_d;
            rd_owner_q   <= rd_owner_d;
        end
    end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - directed self-checking bench for onchip_mem_arbiter
module tb_onchip_mem_arbiter;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_failed;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ram_rd;

    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_readdata = ram_rd;

    always @(posedge clk) begin
        if (bus.mem_chipselect) begin
            if (bus.mem_write) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
                end
            end else begin
                ram_rd <= ram[bus.mem_address];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.m0_read = 0; bus.m0_write = 0; bus.m0_lock = 0;
        bus.m1_read = 0; bus.m1_write = 0; bus.m1_lock = 0;
        bus.m0_address = '0; bus.m1_address = '0;
        bus.m0_byteenable = 4'hF; bus.m1_byteenable = 4'hF;
        bus.m0_writedata = '0; bus.m1_writedata = '0;
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        ram_rd   = '0;
        for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = 32'hC0DE0000 | i;
        idle_all();

        // reset with requests pending
        reset_n = 0;
        bus.m0_read = 1; bus.m1_write = 1;
        step(); step();
        check("rst_m0_wait", bus.m0_waitrequest, 1);
        check("rst_m1_wait", bus.m1_waitrequest, 1);
        check("rst_cs", bus.mem_chipselect, 0);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_m0_rdv", bus.m0_readdatavalid, 0);
        check("rst_m1_rdv", bus.m1_readdatavalid, 0);
        idle_all();
        reset_n = 1;

        // continuous writes from both: m0 wins first, then alternate
        for (int i = 0; i < 6; i++) begin
            bus.m0_write = 1; bus.m0_address = 13'h100; bus.m0_writedata = 32'h10000000 + i/2 + (i%2);
            bus.m1_write = 1; bus.m1_address = 13'h101; bus.m1_writedata = 32'h20000000 + i/2;
            if (i%2 == 1) bus.m0_writedata = 32'h10000000 + i/2 + 1;
            #1;
            check("rr_m0_wait", bus.m0_waitrequest, (i%2 == 1));
            check("rr_m1_wait", bus.m1_waitrequest, (i%2 == 0));
            check("rr_wdata", bus.mem_writedata, (i%2 == 0) ? 32'h10000000 + i/2 : 32'h20000000 + i/2);
            step();
        end
        idle_all();
        step();
        check("rr_ram_m0", ram[13'h100], 32'h10000002);
        check("rr_ram_m1", ram[13'h101], 32'h20000002);

        // single read by m0
        bus.m0_read = 1; bus.m0_address = 13'h0010;
        #1;
        check("rd_m0_wait", bus.m0_waitrequest, 0);
        check("rd_m1_wait", bus.m1_waitrequest, 1);
        check("rd_cs", bus.mem_chipselect, 1);
        check("rd_addr", bus.mem_address, 13'h0010);
        check("rd_mem_write", bus.mem_write, 0);
        step();
        idle_all();
        #1;
        check("rd_m0_rdv", bus.m0_readdatavalid, 1);
        check("rd_m0_data", bus.m0_readdata, 32'hC0DE0010);
        check("rd_m1_rdv", bus.m1_readdatavalid, 0);
        check("rd_m1_data", bus.m1_readdata, 32'hC0DE0010);
        check("idle_cs", bus.mem_chipselect, 0);
        check("idle_mem_write", bus.mem_write, 0);
        check("idle_m0_wait", bus.m0_waitrequest, 1);
        check("idle_m1_wait", bus.m1_waitrequest, 1);
        step();

        // partial byte write at top address, then read back
        bus.m1_write = 1; bus.m1_address = 13'h1FFF; bus.m1_writedata = 32'hDEADBEEF; bus.m1_byteenable = 4'b0011;
        #1;
        check("be_m1_wait", bus.m1_waitrequest, 0);
        check("be_mem_be", bus.mem_byteenable, 4'b0011);
        step();
        idle_all();
        bus.m0_read = 1; bus.m0_address = 13'h1FFF;
        #1;
        check("be_m1_rdv", bus.m1_readdatavalid, 0);
        step();
        idle_all();
        #1;
        check("be_m0_rdv", bus.m0_readdatavalid, 1);
        check("be_m0_data", bus.m0_readdata, 32'hC0DEBEEF);
        step();

        // locked read then unlocked write by m1 while m0 keeps requesting
        bus.m0_write = 1; bus.m0_address = 13'h200; bus.m0_writedata = 32'h33333333;
        bus.m1_read = 1; bus.m1_lock = 1; bus.m1_address = 13'h0010;
        #1;
        check("lk1_m0_wait", bus.m0_waitrequest, 1);
        check("lk1_m1_wait", bus.m1_waitrequest, 0);
        step();
        bus.m1_read = 0; bus.m1_lock = 0; bus.m1_write = 1; bus.m1_address = 13'h300; bus.m1_writedata = 32'h44444444;
        #1;
        check("lk2_m0_wait", bus.m0_waitrequest, 1);
        check("lk2_m1_wait", bus.m1_waitrequest, 0);
        check("lk2_m1_rdv", bus.m1_readdatavalid, 1);
        check("lk2_m1_data", bus.m1_readdata, 32'hC0DE0010);
        check("lk2_m0_rdv", bus.m0_readdatavalid, 0);
        step();
        bus.m1_write = 0;
        #1;
        check("lk3_m0_wait", bus.m0_waitrequest, 0);
        check("lk3_m1_rdv", bus.m1_readdatavalid, 0);
        step();
        idle_all();
        check("lk_ram_m1", ram[13'h300], 32'h44444444);
        check("lk_ram_m0", ram[13'h200], 32'h33333333);

        // idle lock owner keeps m0 stalled
        bus.m1_read = 1; bus.m1_lock = 1; bus.m1_address = 13'h0011;
        step();
        idle_all();
        bus.m0_read = 1; bus.m0_address = 13'h0012;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_m0_wait", bus.m0_waitrequest, 1);
            step();
        end
        bus.m1_read = 1; bus.m1_lock = 0; bus.m1_address = 13'h0013;
        #1;
        check("rel_m1_wait", bus.m1_waitrequest, 0);
        check("rel_m0_wait", bus.m0_waitrequest, 1);
        step();
        bus.m1_read = 0;
        #1;
        check("rel2_m0_wait", bus.m0_waitrequest, 0);
        step();
        idle_all();
        step();

        // alternating pipelined reads
        for (int k = 0; k <= 6; k++) begin
            idle_all();
            if (k < 6) begin
                if (k%2 == 0) begin bus.m0_read = 1; bus.m0_address = 13'h20 + k; end
                else          begin bus.m1_read = 1; bus.m1_address = 13'h20 + k; end
            end
            #1;
            if (k > 0) begin
                check("pipe_m0_rdv", bus.m0_readdatavalid, ((k-1)%2 == 0));
                check("pipe_m1_rdv", bus.m1_readdatavalid, ((k-1)%2 == 1));
                check("pipe_data", bus.m0_readdata, 32'hC0DE0020 + k - 1);
            end
            step();
        end
        idle_all();

        // reset in the cycle after a locked read accept
        bus.m0_read = 1; bus.m0_lock = 1; bus.m0_address = 13'h0010;
        step();
        bus.m1_read = 1;
        reset_n = 0;
        #1;
        check("ar_m0_rdv", bus.m0_readdatavalid, 0);
        check("ar_m1_rdv", bus.m1_readdatavalid, 0);
        check("ar_m0_wait", bus.m0_waitrequest, 1);
        check("ar_m1_wait", bus.m1_waitrequest, 1);
        check("ar_cs", bus.mem_chipselect, 0);
        check("ar_mem_write", bus.mem_write, 0);
        step();
        idle_all();
        reset_n = 1;
        bus.m1_read = 1; bus.m1_address = 13'h0014;
        #1;
        check("ar_post_m0_rdv", bus.m0_readdatavalid, 0);
        check("ar_post_m1_rdv", bus.m1_readdatavalid, 0);
        check("ar_unlock_m1_wait", bus.m1_waitrequest, 0);
        step();
        idle_all();
        #1;
        check("ar_post2_m1_rdv", bus.m1_readdatavalid, 1);
        check("ar_post2_data", bus.m1_readdata, 32'hC0DE0014);
        check("ar_post2_m0_rdv", bus.m0_readdatavalid, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
